// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - two-master Wishbone arbiter with per-transaction grant and stall watchdog
module wb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMO_WIDTH      = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  gnt_o
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 last_gnt_q, last_gnt_d;
    logic [TMO_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

    logic        own_cyc, own_stb, own_we;
    logic [31:0] own_adr, own_dat;
    logic [3:0]  own_sel;
    logic        stalled, tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    always_comb begin
        own_cyc    = 1'b0;
        own_stb    = 1'b0;
        own_we     = 1'b0;
        own_adr    = '0;
        own_dat    = '0;
        own_sel    = '0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        m0_dat_o   = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_rty_o   = 1'b0;
        m1_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_rty_o   = 1'b0;

        case (state_q)
            GNT0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
                own_sel = m0_sel_i;
            end
            GNT1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
                own_sel = m1_sel_i;
            end
            default: ;
        endcase

        // A slave response in the timeout cycle suppresses the local err.
        stalled = own_stb & ~(s_ack_i | s_err_i | s_rty_i);
        tmo_hit = stalled & (tmo_cnt_q == TMO_LAST);

        s_cyc_o = own_cyc;
        s_stb_o = own_stb & ~tmo_hit;
        s_we_o  = own_we;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        s_sel_o = own_sel;

        tmo_cnt_d = (state_q != IDLE && own_cyc && stalled && !tmo_hit)
                    ? tmo_cnt_q + 1'b1 : '0;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_gnt_q ? GNT0 : GNT1;
                else if (m0_cyc_i)        state_d = GNT0;
                else if (m1_cyc_i)        state_d = GNT1;
            end
            GNT0: begin
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_rty_o = s_rty_i;
                m0_err_o = s_err_i | tmo_hit;
                if (!m0_cyc_i) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                end
            end
            GNT1: begin
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_rty_o = s_rty_i;
                m1_err_o = s_err_i | tmo_hit;
                if (!m1_cyc_i) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o = state_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb/tb_wb_master_arbiter.sv - directed self-checking bench for wb_master_arbiter
module tb_wb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  gnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] beat_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    always #5 clk = ~clk;

    wb_master_arbiter #(.TIMEOUT_CYCLES(8), .TMO_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 0;
        s_dat_i = 0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    endtask

    // Cycle boundary: inputs change 1ns after the rising edge, checks 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_scyc", 32'(s_cyc_o), 32'h0);
    endtask

    initial begin
        // Test 1: lone icache refill, 4 beats
        do_reset();
        step(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h8000_0010; #1;
        check("t1_c0_scyc", 32'(s_cyc_o), 32'h0);
        step(); #1;
        check("t1_c1_scyc", 32'(s_cyc_o), 32'h1);
        check("t1_c1_gnt", 32'(gnt_o), 32'h2);
        check("t1_c1_adr", s_adr_o, 32'h8000_0010);
        for (int k = 0; k < 4; k++) begin
            step(); s_ack_i = 1; s_dat_i = beat_d[k]; m1_adr_i = 32'h8000_0010 + 32'(4 * k); #1;
            check("t1_m1_ack", 32'(m1_ack_o), 32'h1);
            check("t1_m1_dat", m1_dat_o, beat_d[k]);
            check("t1_m1_err", 32'(m1_err_o), 32'h0);
            check("t1_m1_rty", 32'(m1_rty_o), 32'h0);
            check("t1_m0_ack", 32'(m0_ack_o), 32'h0);
            check("t1_m0_dat", m0_dat_o, 32'h0);
            check("t1_m0_err", 32'(m0_err_o), 32'h0);
            check("t1_m0_rty", 32'(m0_rty_o), 32'h0);
        end
        step(); idle_inputs(); #1;
        check("t1_c6_gnt", 32'(gnt_o), 32'h2);
        step(); #1;
        check("t1_c7_gnt", 32'(gnt_o), 32'h0);

        // Test 2: tie after reset goes to m0, next tie to m1
        do_reset();
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h1000_0000;
        m0_sel_i = 4'b1111; m0_dat_i = 32'hDEAD_BEEF;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h8000_0100; #1;
        step(); s_ack_i = 1; #1;
        check("t2_gnt0", 32'(gnt_o), 32'h1);
        check("t2_adr", s_adr_o, 32'h1000_0000);
        check("t2_we", 32'(s_we_o), 32'h1);
        check("t2_sel", 32'(s_sel_o), 32'hF);
        check("t2_wdat", s_dat_o, 32'hDEAD_BEEF);
        check("t2_m0_ack", 32'(m0_ack_o), 32'h1);
        check("t2_m1_ack", 32'(m1_ack_o), 32'h0);
        step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; #1;
        step(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000_0004; #1;
        check("t2_turn_gnt", 32'(gnt_o), 32'h0);
        check("t2_turn_ack", 32'(m0_ack_o), 32'h0);
        step(); s_ack_i = 1; #1;
        check("t2_gnt1", 32'(gnt_o), 32'h2);
        check("t2_adr1", s_adr_o, 32'h8000_0100);
        check("t2_m1_ack", 32'(m1_ack_o), 32'h1);
        check("t2_m0_iso", 32'(m0_ack_o), 32'h0);
        step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; #1;
        step(); #1;
        check("t2_idle2", 32'(gnt_o), 32'h0);
        step(); #1;
        check("t2_gnt0b", 32'(gnt_o), 32'h1);
        step(); idle_inputs(); #1;
        step(); #1;

        // Test 3: m0 arrives mid-burst, waits for burst end plus turnaround
        step(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h8000_0200; #1;
        step(); #1;
        for (int k = 0; k < 4; k++) begin
            step(); s_ack_i = 1; s_dat_i = beat_d[k]; m1_adr_i = 32'h8000_0200 + 32'(4 * k);
            if (k == 1) begin
                m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000_0040;
            end
            #1;
            check("t3_adr", s_adr_o, 32'h8000_0200 + 32'(4 * k));
            check("t3_gnt", 32'(gnt_o), 32'h2);
            check("t3_m0_ack", 32'(m0_ack_o), 32'h0);
        end
        step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; #1;
        step(); #1;
        check("t3_turn", 32'(gnt_o), 32'h0);
        check("t3_turn_cyc", 32'(s_cyc_o), 32'h0);
        step(); #1;
        check("t3_gnt0", 32'(gnt_o), 32'h1);
        check("t3_adr0", s_adr_o, 32'h1000_0040);
        step(); idle_inputs(); #1;
        step(); #1;

        // Test 4: stall watchdog fires on the 8th stalled cycle
        step(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000_0080; #1;
        for (int c = 1; c <= 9; c++) begin
            step(); #1;
            check("t4_err", 32'(m0_err_o), (c == 8) ? 32'h1 : 32'h0);
            check("t4_stb", 32'(s_stb_o), (c == 8) ? 32'h0 : 32'h1);
        end
        check("t4_gnt_held", 32'(gnt_o), 32'h1);

        // Test 5: ack on the timeout cycle wins and restarts the count
        for (int c = 10; c <= 15; c++) begin
            step(); #1;
            check("t5_pre_err", 32'(m0_err_o), 32'h0);
        end
        step(); s_ack_i = 1; #1;
        check("t5_ack", 32'(m0_ack_o), 32'h1);
        check("t5_err", 32'(m0_err_o), 32'h0);
        check("t5_stb", 32'(s_stb_o), 32'h1);
        for (int c = 1; c <= 8; c++) begin
            step(); s_ack_i = 0; #1;
            check("t5_post_err", 32'(m0_err_o), (c == 8) ? 32'h1 : 32'h0);
        end
        step(); idle_inputs(); #1;
        step(); #1;

        // Test 6: async reset during beat 3 of a refill
        step(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h8000_0300; #1;
        step(); #1;
        step(); s_ack_i = 1; #1;
        step(); #1;
        step(); s_ack_i = 0; m1_adr_i = 32'h8000_0308; #1;
        check("t6_pre_cyc", 32'(s_cyc_o), 32'h1);
        #2;
        rst = 1'b1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000_0100;
        #1;
        check("t6_rst_cyc", 32'(s_cyc_o), 32'h0);
        check("t6_rst_stb", 32'(s_stb_o), 32'h0);
        check("t6_rst_gnt", 32'(gnt_o), 32'h0);
        check("t6_rst_adr", s_adr_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rel_gnt", 32'(gnt_o), 32'h0);
        step(); #1;
        check("t6_gnt0", 32'(gnt_o), 32'h1);
        check("t6_adr0", s_adr_o, 32'h1000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the single memory bus between the instruction-cache refill port (m1) and the data-memory/MEM-stage port (m0).
- Grants the bus per transaction: the grant is held for as long as the owner keeps cyc high, so the 4-beat icache line refill is never split.
- Round-robin on contention.
- A per-transaction timeout watchdog returns err to the owner if the slave stalls.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive stalled cycles (stb high, no ack/err/rty) before a local err is generated.
- TMO_WIDTH, 11: counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  data master strobes
- m0_adr_i, m0_dat_i  in  32 each  data master address/write data
- m0_sel_i  in  4  data master byte select
- m0_dat_o  out  32  read data to data master
- m0_ack_o, m0_err_o, m0_rty_o  out  1 each  responses to data master
- m1_cyc_i, m1_stb_i, m1_we_i  in  1 each  icache master strobes
- m1_adr_i, m1_dat_i  in  32 each  icache master address/write data
- m1_sel_i  in  4  icache master byte select
- m1_dat_o  out  32  read data to icache
- m1_ack_o, m1_err_o, m1_rty_o  out  1 each  responses to icache
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o, s_dat_o  out  32 each  to slave
- s_sel_o  out  4  to slave
- s_dat_i  in  32  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave responses
- gnt_o  out  2  one-hot current grant (bit0=m0, bit1=m1), debug/perf

Behaviour:
- FSM states: IDLE, GNT0, GNT1, all registered. Reset puts the FSM in IDLE with last_gnt=1, so m0 wins the first tie, and tmo_cnt=0.
- IDLE transitions:
  - m0_cyc_i & m1_cyc_i: go to GNT0 if last_gnt==1, else GNT1.
  - Only m0_cyc_i: go to GNT0.
  - Only m1_cyc_i: go to GNT1.
  - Neither: stay in IDLE.
- IDLE outputs: s_cyc_o=s_stb_o=s_we_o=0; s_adr_o=s_dat_o=0; s_sel_o=0; gnt_o=00. Arbitration latency is exactly 1 cycle: a cyc raised at cycle N reaches the slave at N+1.
- GNTn transitions: the owner holds the grant while mn_cyc_i=1. When mn_cyc_i=0, go to IDLE and set last_gnt=n. Every ownership change passes through one IDLE turnaround cycle; there is no back-to-back handoff.
- GNTn outputs:
  - s_* follow mn_* combinationally; s_cyc_o=mn_cyc_i; s_stb_o=mn_stb_i & ~tmo_hit.
  - mn_dat_o=s_dat_i; mn_ack_o=s_ack_i; mn_rty_o=s_rty_i; mn_err_o=s_err_i | tmo_hit.
  - These paths are combinational, with zero added response latency.
- Non-owner isolation: the non-owner master always sees ack/err/rty=0 and dat_o=0. Slave responses arriving in IDLE are dropped.
- Watchdog counter:
  - In GNTn, tmo_cnt increments each cycle with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - Any response, or stb low, clears it. Leaving GNTn clears it.
  - tmo_hit = (tmo_cnt == TIMEOUT_CYCLES-1) & stalled.
  - In the tmo_hit cycle: a one-cycle mn_err_o pulse, slave stb masked, counter cleared. The grant is retained until the master drops cyc.
- Simultaneous events:
  - A slave response in the same cycle as tmo_hit: the slave response wins; no timeout err and the counter clears.
  - Owner drops cyc in the same cycle the other master raises cyc: IDLE next cycle, then the other master is granted.
- Multi-beat bursts: the icache keeps cyc high across all 4 beats, so m0 cannot intervene mid-line. m0 waits for at most 4 beats plus the turnaround cycle.
- Reset mid-transaction: the FSM is forced to IDLE asynchronously and all s_* outputs drop to 0. Masters are responsible for their own reset.
- gnt_o is registered state decode: IDLE=00, GNT0=01, GNT1=10.

Test Plan:
1. Only m1 raises cyc/stb at cycle 0, adr=0x8000_0010. The slave acks 4 beats on cycles 2-5 with data 0x11,0x22,0x33,0x44. Required: s_cyc_o=1 from cycle 1; m1_dat_o delivers 0x11..0x44 in order; m1 drops cyc at 6 -> gnt_o=00 at cycle 7; m0 sees no ack.
2. m0 and m1 raise cyc together right after reset. Required: GNT0 first. After m0 completes a single write to adr=0x1000_0000 with sel=4'b1111, the next tie goes to GNT1.
3. Contention mid-burst: m0 raises cyc during m1's beat 2. Required: s_adr_o stays on m1 addresses through beat 4; m0 is granted exactly 2 cycles after m1 drops cyc.
4. Timeout with TIMEOUT_CYCLES=8: m0 stb held and the slave never responds. Required: m0_err_o pulses 1 cycle, 8 cycles after s_stb_o rose; s_stb_o=0 in that cycle.
5. Timeout collision: s_ack_i arrives exactly on the timeout cycle. Required: m0_ack_o=1, m0_err_o=0, counter=0.
6. rst asserted in GNT1 during beat 3. Required: s_cyc_o=0 and gnt_o=00 immediately (asynchronously). After release with both cyc high, m0 is granted first.
